reg_file_param: RTL and testbench
=================================

// Module: reg_file_param
// PURPOSE
//  Parametrised multi-read, single-write register file for the CPU datapath.
//  Generalises the 2R/1W fixed 9x32 register array: configurable width/depth,
//  hardwired-zero register option, synchronous reset that sweeps all entries to zero.
//  Sits between decode (read addresses) and writeback (write port).
// PARAMETERS
//  DW        32  data width in bits
//  DEPTH     32  number of registers (>=2, need not be a power of 2)
//  AW        5   address width; must satisfy 2**AW >= DEPTH
//  ZERO_REG  1   1: entry 0 always reads 0, writes to it dropped; 0: ordinary entry
// PORTS
//  clk     in   1    clock, all state updates on rising edge
//  rst     in   1    synchronous active-high reset
//  WE_Reg  in   1    write enable
//  WD_Reg  in   DW   write data
//  A1      in   AW   read address, port 1
//  A2      in   AW   read address, port 2
//  A3      in   AW   write address
//  RD1     out  DW   read data, port 1 (combinational)
//  RD2     out  DW   read data, port 2 (combinational)
//  busy    out  1    1 while the clear sweep runs; writes ignored, reads return 0
// BEHAVIOUR
//  - FSM states CLEAR, READY. A clk edge with rst=1 -> CLEAR, sweep cnt<=0.
//  - CLEAR: each edge writes 0 to mem[cnt], cnt++; edge where cnt==DEPTH-1
//    -> READY. Sweep takes exactly DEPTH cycles after rst deasserts.
//  - rst asserted mid-sweep restarts the sweep at cnt=0.
//  - busy = (state==CLEAR); RD1/RD2 = 0 while busy. busy=1 the cycle after
//    the reset edge; before the first reset busy/RD* are undefined.
//  - READY: edge with WE_Reg=1 and A3<DEPTH writes WD_Reg to mem[A3];
//    A3>=DEPTH or (ZERO_REG and A3==0) -> write dropped, no state change.
//  - Reads: RDn = mem[An], combinational; An>=DEPTH -> 0; ZERO_REG and An==0 -> 0.
//  - A1==A2 returns identical data on both ports.
//  - Write then read of same address: new value visible from the cycle after the edge.
//  - WE_Reg during CLEAR or on an edge with rst=1 is discarded (not queued).
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: in READY, if WE_Reg=1, A3 is a writable address
//    and An==A3, RDn = WD_Reg in the same cycle (write-to-read forwarding),
//    with priority over the array value; ZERO_REG/out-of-range rules still win.
//  Not defined: RDn always returns the stored array value (old value during
//    the write cycle).
// TESTING
//  1 rst=1 one edge, then rst=0 -> busy=1 for exactly DEPTH edges (32), then 0;
//    afterwards every A1 in 0..31 reads 0.
//  2 READY, WE_Reg=1,A3=5,WD_Reg=32'h8 -> next cycle A1=5 gives RD1=32'h8,
//    A2=5 gives RD2=32'h8.
//  3 ZERO_REG=1, write A3=0 WD=32'hFFFF_FFFF -> RD1 at A1=0 stays 0;
//    DEPTH=9,AW=4: write A3=12 dropped, A1=12 reads 0.
//  4 Write A3=3 WD=32'h1234 with A1=3 same cycle -> RD1=32'h1234 with
//    REGFILE_BYPASS_EN, previous value (0 after sweep) without it.
//  5 rst at sweep cnt=10 -> sweep restarts; busy stays 1 for a further 32
//    cycles; writes issued while busy leave entries 0.
//  6 Back-to-back writes A3=7 (32'hA) then A3=7 (32'hB) -> RD1 at A1=7 reads
//    32'hA then 32'hB on consecutive cycles.

Source files
------------

// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_param
//  Description : Parametrised two-read / one-write register file for the CPU
//                datapath. It has a configurable width and depth and an
//                optional hardwired-zero entry 0. A synchronous reset starts a
//                sweep that writes zero into every entry, one entry per clock.
//  Ports       : clk     - clock; all state changes on the rising edge
//                rst     - synchronous active-high reset; restarts the sweep
//                WE_Reg  - write enable
//                WD_Reg  - write data [DW-1:0]
//                A1, A2  - read addresses [AW-1:0]
//                A3      - write address [AW-1:0]
//                RD1,RD2 - combinational read data [DW-1:0]
//                busy    - high while the clear sweep runs
//  Options     : REGFILE_BYPASS_EN - when defined, a write is forwarded to a
//                read port that addresses the same entry in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_param #(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          WE_Reg,
    input  logic [DW-1:0] WD_Reg,
    input  logic [AW-1:0] A1,
    input  logic [AW-1:0] A2,
    input  logic [AW-1:0] A3,
    output logic [DW-1:0] RD1,
    output logic [DW-1:0] RD2,
    output logic          busy
);

    // One extra bit so that DEPTH == 2**AW is representable.
    localparam logic [AW:0]   c_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_LAST  = AW'(DEPTH - 1);
    localparam bit            c_ZERO  = (ZERO_REG != 0);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_cnt;
    logic [DW-1:0] r_mem [DEPTH];
    logic          w_wr_ok;

    // An address is usable when it lies inside the array and is not the
    // hardwired-zero entry.
    function automatic logic f_valid(input logic [AW-1:0] addr);
        return ({1'b0, addr} < c_DEPTH) && !(c_ZERO && (addr == '0));
    endfunction

    // ------------------------------------------------------------------
    // State register and sweep counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == CLEAR) begin
                r_cnt <= r_cnt + AW'(1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            CLEAR:   if (r_cnt == c_LAST) w_next = READY;
            READY:   w_next = READY;
            default: w_next = CLEAR;
        endcase
    end

    assign busy = (r_state == CLEAR);

    // Writes only land in READY; anything presented during the sweep or on
    // a reset edge is simply dropped.
    assign w_wr_ok = WE_Reg && (r_state == READY) && f_valid(A3);

    // ------------------------------------------------------------------
    // Storage: the sweep and normal writes share the single write port.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == CLEAR) begin
                r_mem[r_cnt] <= '0;
            end else if (w_wr_ok) begin
                r_mem[A3] <= WD_Reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    function automatic logic [DW-1:0] f_read(input logic [AW-1:0] addr);
        logic [DW-1:0] data;
        data = '0;
        if ((r_state == READY) && f_valid(addr)) begin
            data = r_mem[addr];
`ifdef REGFILE_BYPASS_EN
            // Forward the in-flight write so the reader sees it this cycle.
            if (w_wr_ok && (addr == A3)) begin
                data = WD_Reg;
            end
`endif
        end
        return data;
    endfunction

    always_comb begin
        RD1 = f_read(A1);
    end

    always_comb begin
        RD2 = f_read(A2);
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_param
//  Description : Self-checking bench for reg_file_param. Two instances: the
//                default 32x32 configuration and a 9-entry, 4-bit-address one.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_param;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    // default instance
    logic        we;
    logic [31:0] wd;
    logic [4:0]  a1, a2, a3;
    logic [31:0] rd1, rd2;
    logic        busy;
    // small instance
    logic        b_we;
    logic [31:0] b_wd;
    logic [3:0]  b_a1, b_a2, b_a3;
    logic [31:0] b_rd1, b_rd2;
    logic        b_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_file_param #(.DW(32), .DEPTH(32), .AW(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .WE_Reg(we), .WD_Reg(wd),
        .A1(a1), .A2(a2), .A3(a3), .RD1(rd1), .RD2(rd2), .busy(busy)
    );

    reg_file_param #(.DW(32), .DEPTH(9), .AW(4), .ZERO_REG(1)) dut_small (
        .clk(clk), .rst(rst), .WE_Reg(b_we), .WD_Reg(b_wd),
        .A1(b_a1), .A2(b_a2), .A3(b_a3), .RD1(b_rd1), .RD2(b_rd2), .busy(b_busy)
    );

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;   // expected RD1 without forwarding
        logic [31:0] e2;
        logic [31:0] e1b;  // expected RD1 with forwarding
        logic [31:0] e2b;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Count edges until each instance leaves the sweep; writes are offered
    // to the default instance the whole time and must be ignored.
    task automatic count_sweep(input string tag, input int exp_big, input int exp_small);
        int n_big;
        int n_small;
        n_big = 0;
        n_small = 0;
        for (int e = 1; e <= 40; e++) begin
            we = 1'b1;
            a3 = 5'(e % 32);
            wd = 32'hFFFF_0000 | 32'(e);
            tick();
            if (!busy && n_big == 0) n_big = e;
            if (!b_busy && n_small == 0) n_small = e;
            if (n_big != 0 && n_small != 0) break;
        end
        we = 1'b0;
        chk({tag, "_sweep_len"}, 32'(n_big), 32'(exp_big));
        chk({tag, "_sweep_len_small"}, 32'(n_small), 32'(exp_small));
    endtask

    task automatic all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i);
            a2 = 5'(31 - i);
            #1;
            chk({tag, "_zero_rd1"}, rd1, 32'h0);
            chk({tag, "_zero_rd2"}, rd2, 32'h0);
        end
    endtask

    initial begin
        //               we  a3  wd            a1  a2  e1            e2            e1b           e2b
        vecs[0]  = '{1'b1, 5,  32'h8,        5,  0,  32'h0,        32'h0,        32'h8,        32'h0};
        vecs[1]  = '{1'b0, 0,  32'h0,        5,  5,  32'h8,        32'h8,        32'h8,        32'h8};
        vecs[2]  = '{1'b1, 0,  32'hFFFF_FFFF, 0, 5,  32'h0,        32'h8,        32'h0,        32'h8};
        vecs[3]  = '{1'b0, 0,  32'h0,        0,  0,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[4]  = '{1'b1, 3,  32'h1234,     3,  5,  32'h0,        32'h8,        32'h1234,     32'h8};
        vecs[5]  = '{1'b0, 0,  32'h0,        3,  3,  32'h1234,     32'h1234,     32'h1234,     32'h1234};
        vecs[6]  = '{1'b1, 7,  32'hA,        7,  3,  32'h0,        32'h1234,     32'hA,        32'h1234};
        vecs[7]  = '{1'b1, 7,  32'hB,        7,  7,  32'hA,        32'hA,        32'hB,        32'hB};
        vecs[8]  = '{1'b0, 0,  32'h0,        7,  31, 32'hB,        32'h0,        32'hB,        32'h0};
        vecs[9]  = '{1'b1, 31, 32'hDEADBEEF, 31, 30, 32'h0,        32'h0,        32'hDEADBEEF, 32'h0};
        vecs[10] = '{1'b0, 0,  32'h0,        31, 5,  32'hDEADBEEF, 32'h8,        32'hDEADBEEF, 32'h8};
        vecs[11] = '{1'b1, 5,  32'h5555,     7,  5,  32'hB,        32'h8,        32'hB,        32'h5555};
        vecs[12] = '{1'b0, 0,  32'h0,        5,  5,  32'h5555,     32'h5555,     32'h5555,     32'h5555};

        rst = 1'b1;
        we = 1'b0; wd = '0; a1 = '0; a2 = '0; a3 = '0;
        b_we = 1'b0; b_wd = '0; b_a1 = '0; b_a2 = '0; b_a3 = '0;

        // ---- reset and sweep length ----
        tick();
        rst = 1'b0;
        a1 = 5'd5;
        a2 = 5'd31;
        #1;
        chk("reset_busy", 32'(busy), 32'h1);
        chk("reset_busy_small", 32'(b_busy), 32'h1);
        chk("busy_rd1", rd1, 32'h0);
        chk("busy_rd2", rd2, 32'h0);
        count_sweep("first", 32, 9);
        all_zero("first");

        // ---- table-driven READY traffic ----
        for (int i = 0; i < 13; i++) begin
            we = vecs[i].we;
            a3 = vecs[i].a3;
            wd = vecs[i].wd;
            a1 = vecs[i].a1;
            a2 = vecs[i].a2;
            #1;
            chk($sformatf("vec%0d_rd1", i), rd1, BYP ? vecs[i].e1b : vecs[i].e1);
            chk($sformatf("vec%0d_rd2", i), rd2, BYP ? vecs[i].e2b : vecs[i].e2);
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
            tick();
        end
        we = 1'b0;

        // ---- 9-entry instance: out-of-range and zero-register writes ----
        b_we = 1'b1; b_a3 = 4'd12; b_wd = 32'hFFFF_FFFF; b_a1 = 4'd12; b_a2 = 4'd9;
        #1;
        chk("small_oor_same_cycle", b_rd1, 32'h0);
        tick();
        b_a3 = 4'd8; b_wd = 32'h77;
        #1;
        chk("small_oor_after", b_rd1, 32'h0);
        chk("small_a9", b_rd2, 32'h0);
        tick();
        b_a3 = 4'd0; b_wd = 32'hFF; b_a1 = 4'd8; b_a2 = 4'd12;
        #1;
        chk("small_last_entry", b_rd1, 32'h77);
        chk("small_oor_rd2", b_rd2, 32'h0);
        tick();
        b_we = 1'b0; b_a1 = 4'd0; b_a2 = 4'd8;
        #1;
        chk("small_zero_reg", b_rd1, 32'h0);
        chk("small_last_hold", b_rd2, 32'h77);

        // ---- reset part-way through a sweep ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int e = 0; e < 10; e++) begin
            we = 1'b1; a3 = 5'd7; wd = 32'h9999;
            tick();
        end
        we = 1'b0;
        chk("mid_sweep_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("restart_busy", 32'(busy), 32'h1);
        count_sweep("restart", 32, 9);
        all_zero("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
